// File: rtl/temp_setpoint.sv
// Oven setpoint entry: two debounced pushbuttons raise/lower a clamped temperature setpoint.
// Define TEMP_SETPOINT_AUTO_REPEAT_EN to add hold-to-repeat; otherwise one step per press.
module temp_setpoint #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100,
  parameter int unsigned T_MIN           = 200,
  parameter int unsigned T_MAX           = 550,
  parameter int unsigned T_DEFAULT       = 350,
  parameter int unsigned STEP            = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up_n,
  input  logic       btn_dn_n,
  input  logic       lock,
  output logic [9:0] target_temp,
  output logic       changed,
  output logic       at_limit
);

  // 64-bit product so large clock rates with long intervals cannot overflow.
  function automatic int unsigned ms_to_cyc(input int unsigned ms);
    longint unsigned c;
    c = (64'(ms) * 64'(CLK_HZ)) / 64'd1000;
    return (c == 64'd0) ? 32'd1 : 32'(c);
  endfunction

  localparam int unsigned DbCyc = ms_to_cyc(DEBOUNCE_MS);
  localparam int unsigned DbW   = $clog2(DbCyc + 1);

  if (T_MAX > 1023 || T_MIN > T_DEFAULT || T_DEFAULT > T_MAX || STEP == 0 ||
      REPEAT_DELAY_MS == 0 || REPEAT_RATE_MS == 0) begin : g_bad_cfg
    $error("temp_setpoint: invalid parameter set");
  end

`ifdef TEMP_SETPOINT_AUTO_REPEAT_EN
  localparam int unsigned RptDly = ms_to_cyc(REPEAT_DELAY_MS);
  localparam int unsigned RptRat = ms_to_cyc(REPEAT_RATE_MS);
  localparam int unsigned RptMax = (RptDly > RptRat) ? RptDly : RptRat;
  localparam int unsigned RptW   = $clog2(RptMax + 1);
  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} btn_state_e;
`else
  typedef enum logic {StIdle, StHeld} btn_state_e;
`endif

  // Index 0 = up, 1 = down.
  logic [1:0] btn_raw;
  logic [1:0] db_lvl;
  logic [1:0] step_ev;
  logic       both_q;
  logic       suppress;

  assign btn_raw = {btn_dn_n, btn_up_n};

  // Chord lockout persists until both buttons are released again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      both_q <= 1'b0;
    end else if (db_lvl == 2'b00) begin
      both_q <= 1'b1;
    end else if (db_lvl == 2'b11) begin
      both_q <= 1'b0;
    end
  end

  assign suppress = lock | both_q | (db_lvl == 2'b00);

  for (genvar b = 0; b < 2; b++) begin : g_btn
    logic [1:0]     sync_q;
    logic           db_q;
    logic           db_prev_q;
    logic [DbW-1:0] db_cnt_q;
    logic           press;
    logic           step;
    btn_state_e     state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q    <= 2'b11;
        db_q      <= 1'b1;
        db_prev_q <= 1'b1;
        db_cnt_q  <= '0;
      end else begin
        sync_q    <= {sync_q[0], btn_raw[b]};
        db_prev_q <= db_q;
        if (sync_q[1] != db_q) begin
          if (db_cnt_q == DbW'(DbCyc - 1)) begin
            db_q     <= sync_q[1];
            db_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_q <= '0;
        end
      end
    end

    assign press = db_prev_q & ~db_q;

`ifdef TEMP_SETPOINT_AUTO_REPEAT_EN
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= StIdle;
        rpt_cnt_q <= '0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      step      = 1'b0;
      if (suppress || db_q) begin
        state_d   = StIdle;
        rpt_cnt_d = '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (press) begin
              step      = 1'b1;
              state_d   = StDelay;
              rpt_cnt_d = '0;
            end
          end
          StDelay: begin
            if (rpt_cnt_q == RptW'(RptDly - 1)) begin
              step      = 1'b1;
              state_d   = StRepeat;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
          StRepeat: begin
            if (rpt_cnt_q == RptW'(RptRat - 1)) begin
              step      = 1'b1;
              rpt_cnt_d = '0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d   = StIdle;
            rpt_cnt_d = '0;
          end
        endcase
      end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
      end else begin
        state_q <= state_d;
      end
    end

    always_comb begin
      state_d = state_q;
      step    = 1'b0;
      if (suppress || db_q) begin
        state_d = StIdle;
      end else if (state_q == StIdle && press) begin
        step    = 1'b1;
        state_d = StHeld;
      end
    end
`endif

    assign db_lvl[b]  = db_q;
    assign step_ev[b] = step;
  end

  logic [9:0]  temp_q, temp_d;
  logic        changed_q;
  logic [10:0] up_sum;

  assign up_sum = {1'b0, temp_q} + 11'(STEP);

  always_comb begin
    temp_d = temp_q;
    if (step_ev == 2'b01) begin
      temp_d = (up_sum > 11'(T_MAX)) ? 10'(T_MAX) : up_sum[9:0];
    end else if (step_ev == 2'b10) begin
      temp_d = ({1'b0, temp_q} < (11'(T_MIN) + 11'(STEP))) ? 10'(T_MIN) : temp_q - 10'(STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q    <= 10'(T_DEFAULT);
      changed_q <= 1'b0;
    end else begin
      temp_q    <= temp_d;
      changed_q <= (temp_d != temp_q);
    end
  end

  assign target_temp = temp_q;
  assign changed     = changed_q;
  assign at_limit    = (temp_q == 10'(T_MIN)) || (temp_q == 10'(T_MAX));

endmodule

// File: tb/tb_temp_setpoint.sv
// Directed bench for temp_setpoint at CLK_HZ=1000 (1 ms per cycle); a queue holds the
// setpoint each expected changed pulse must present.
module tb_temp_setpoint;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up_n = 1'b1;
  logic       btn_dn_n = 1'b1;
  logic       lock = 1'b0;
  logic [9:0] target_temp;
  logic       changed;
  logic       at_limit;

  int errors = 0;
  int checks = 0;
  int chg_cnt = 0;
  int base = 0;
  int n_hold = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_t;

  temp_setpoint #(.CLK_HZ(1000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up_n   (btn_up_n),
    .btn_dn_n   (btn_dn_n),
    .lock       (lock),
    .target_temp(target_temp),
    .changed    (changed),
    .at_limit   (at_limit)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Each changed pulse must match the oldest outstanding expected setpoint.
  always @(negedge clk) begin
    if (rst_n && changed) begin
      chg_cnt++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra_pulse: got target_temp=%0d expected no pulse", target_temp);
      end
      if (exp_q.size() != 0) begin
        exp_t = exp_q.pop_front();
        checks++;
        assert (target_temp === exp_t) else begin
          errors++;
          $error("FAIL sb_value: got %0d expected %0d", target_temp, exp_t);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input int hold);
    if (up) btn_up_n = 1'b0;
    else    btn_dn_n = 1'b0;
    cycles(hold);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    cycles(40);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      cycles(1);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  task automatic reset_mid(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check({tag, "_target"}, target_temp, 350);
    check({tag, "_changed"}, changed, 0);
    check({tag, "_limit"}, at_limit, 0);
  endtask

  task automatic reset_to_default(input string tag);
    reset_mid(tag);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
  endtask

  initial begin
    // Reset state
    cycles(3);
    check("rst_target", target_temp, 350);
    check("rst_changed", changed, 0);
    check("rst_limit", at_limit, 0);
    rst_n = 1'b1;
    cycles(1);
    check("post_rst_changed", changed, 0);
    cycles(5);

    // Single clean up press
    base = chg_cnt;
    exp_q.push_back(10'd355);
    press(1'b1, 30);
    drain("up_drain");
    check("up_target", target_temp, 355);
    check("up_pulses", chg_cnt - base, 1);
    check("up_limit", at_limit, 0);

    // Bouncing down button never settles long enough
    base = chg_cnt;
    for (int i = 0; i < 5; i++) begin
      btn_dn_n = 1'b0;
      cycles(5);
      btn_dn_n = 1'b1;
      cycles(5);
    end
    cycles(40);
    check("bounce_target", target_temp, 355);
    check("bounce_pulses", chg_cnt - base, 0);

    // Long hold from 350: press step, then +500, then every 100 while held
    reset_to_default("hold_rst");
`ifdef TEMP_SETPOINT_AUTO_REPEAT_EN
    n_hold = 7;
`else
    n_hold = 1;
`endif
    for (int i = 1; i <= n_hold; i++) exp_q.push_back(10'(350 + 5 * i));
    btn_up_n = 1'b0;
    cycles(1010);
    btn_up_n = 1'b1;
    cycles(40);
    drain("hold_drain");
    check("hold_target", target_temp, 350 + 5 * n_hold);

    // Upper clamp
    reset_to_default("lim_rst");
    for (int i = 1; i <= 39; i++) begin
      exp_q.push_back(10'(350 + 5 * i));
      press(1'b1, 30);
    end
    drain("to545_drain");
    check("at545_target", target_temp, 545);
    check("at545_limit", at_limit, 0);
    exp_q.push_back(10'd550);
    press(1'b1, 30);
    drain("to550_drain");
    check("at550_target", target_temp, 550);
    check("at550_limit", at_limit, 1);
    base = chg_cnt;
    press(1'b1, 30);
    check("clamp_hi_pulses", chg_cnt - base, 0);
    check("clamp_hi_target", target_temp, 550);
    check("clamp_hi_limit", at_limit, 1);

    // Lower clamp
    for (int i = 1; i <= 69; i++) begin
      exp_q.push_back(10'(550 - 5 * i));
      press(1'b0, 30);
    end
    drain("to205_drain");
    check("at205_target", target_temp, 205);
    check("at205_limit", at_limit, 0);
    exp_q.push_back(10'd200);
    press(1'b0, 30);
    drain("to200_drain");
    check("at200_target", target_temp, 200);
    check("at200_limit", at_limit, 1);
    base = chg_cnt;
    press(1'b0, 30);
    check("clamp_lo_pulses", chg_cnt - base, 0);
    check("clamp_lo_target", target_temp, 200);

    // Both buttons together
    reset_to_default("both_rst");
    base = chg_cnt;
    btn_up_n = 1'b0;
    btn_dn_n = 1'b0;
    cycles(700);
    btn_up_n = 1'b1;
    btn_dn_n = 1'b1;
    cycles(40);
    check("both_target", target_temp, 350);
    check("both_pulses", chg_cnt - base, 0);

    // Lock during press, then unlock with the button still held
    base = chg_cnt;
    lock = 1'b1;
    btn_up_n = 1'b0;
    cycles(60);
    lock = 1'b0;
    cycles(700);
    btn_up_n = 1'b1;
    cycles(40);
    check("lock_target", target_temp, 350);
    check("lock_pulses", chg_cnt - base, 0);
    exp_q.push_back(10'd355);
    press(1'b1, 30);
    drain("unlock_drain");
    check("unlock_target", target_temp, 355);

    // Reset while repeating abandons the repeat
    reset_to_default("rpt_rst");
`ifdef TEMP_SETPOINT_AUTO_REPEAT_EN
    n_hold = 10;
`else
    n_hold = 1;
`endif
    for (int i = 1; i <= n_hold; i++) exp_q.push_back(10'(350 + 5 * i));
    btn_up_n = 1'b0;
    for (int n = 0; n < 3000 && target_temp != 10'(350 + 5 * n_hold); n++) cycles(1);
    check("rpt_reach", target_temp, 350 + 5 * n_hold);
    cycles(20);
    check("rpt_sb_empty", exp_q.size(), 0);
    reset_mid("rpt_mid");
    cycles(5);
    btn_up_n = 1'b1;
    cycles(5);
    rst_n = 1'b1;
    base = chg_cnt;
    cycles(700);
    check("rpt_after_target", target_temp, 350);
    check("rpt_after_pulses", chg_cnt - base, 0);
    exp_q.push_back(10'd355);
    press(1'b1, 30);
    drain("repress_drain");
    check("repress_target", target_temp, 355);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/temp_setpoint.md
TEMP_SETPOINT -- requirements
Module: temp_setpoint

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 20, button stable time before a level is accepted.
REQ-003 Parameter REPEAT_DELAY_MS, default 500, hold time before auto-repeat starts.
REQ-004 Parameter REPEAT_RATE_MS, default 100, auto-repeat step interval.
REQ-005 Parameters T_MIN/T_MAX/T_DEFAULT/STEP, defaults 200/550/350/5, setpoint bounds, reset value and increment, degrees F.
REQ-006 clk  input  1  system clock, one clock domain, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 btn_up_n  input  1  raw raise-temperature pushbutton, active-low, asynchronous to clk.
REQ-009 btn_dn_n  input  1  raw lower-temperature pushbutton, active-low, asynchronous to clk.
REQ-010 lock  input  1  synchronous; 1 = oven running, setpoint frozen.
REQ-011 target_temp  output  10  current setpoint, unsigned binary, feeds the temperature-to-BCD display converter.
REQ-012 changed  output  1  one-cycle pulse when target_temp takes a new value.
REQ-013 at_limit  output  1  level; 1 when target_temp equals T_MIN or T_MAX.

Function
REQ-014 Each raw button SHALL pass through a two-flop synchronizer before any other logic.
REQ-015 Debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_MS*CLK_HZ/1000 consecutive cycles; any bounce restarts the count.
REQ-016 A press event SHALL be the debounced level going 1->0 (pressed); release generates no event.
REQ-017 Per button FSM: IDLE -> (press event) DELAY -> (REPEAT_DELAY elapsed, still held) REPEAT -> (each REPEAT_RATE elapsed) REPEAT; any state -> IDLE on debounced release.
REQ-018 Step events SHALL occur on press event, on DELAY->REPEAT transition, and at every REPEAT_RATE interval in REPEAT.
REQ-019 Up step: target_temp <= min(target_temp+STEP, T_MAX); down step: max(target_temp-STEP, T_MIN); arithmetic in 11 bits, no wrap-around.
REQ-020 target_temp SHALL update on the clock edge following the cycle the step event is generated (1-cycle latency).
REQ-021 changed SHALL assert in the same cycle target_temp presents the new value, only if the value differs from the prior one; clamped steps produce no pulse.
REQ-022 If both debounced buttons are pressed in the same cycle, all step events SHALL be suppressed and both FSMs held in IDLE until both are released.
REQ-023 While lock=1, step events SHALL be discarded, FSMs forced to IDLE, target_temp held; deasserting lock with a button held SHALL NOT generate a step until a new press.
REQ-024 at_limit SHALL be combinationally derived from target_temp.

Reset
REQ-025 rst_n=0 SHALL immediately set target_temp=T_DEFAULT, changed=0, FSMs IDLE, debounced levels released (1), all counters 0.
REQ-026 Reset asserted mid-hold SHALL abandon repeat; after release a held button needs debounce plus a fresh press to step.
REQ-027 Reset deassertion is synchronized externally; no step SHALL occur in the first cycle after release.

Configuration
REQ-028 Macro TEMP_SETPOINT_AUTO_REPEAT_EN: defined -> DELAY/REPEAT states and repeat timers present per REQ-017/018.
REQ-029 Without TEMP_SETPOINT_AUTO_REPEAT_EN: one step per press only; FSM reduces to IDLE/HELD, no repeat counter logic synthesized.

Verification (CLK_HZ=1000, defaults otherwise: 1 ms = 1 cycle)
REQ-030 Reset, single clean btn_up_n press 30 cycles -> target_temp 350->355 once, changed one cycle, at_limit 0.
REQ-031 btn_dn_n bouncing 1/0 every 5 cycles for 50 cycles then released -> no change, changed never asserts.
REQ-032 Hold btn_up_n 1000 cycles from 350 (repeat enabled) -> steps at press, +500, then every 100 cycles: final 355+5*6=385 region exact per count; without macro -> 355.
REQ-033 From 545 press up twice -> 550 with changed once, second press no pulse, at_limit 1; symmetric at 205 -> 200.
REQ-034 Both buttons pressed same cycle, held 700 cycles -> target_temp unchanged; lock=1 with press -> unchanged, release lock while held -> no step.
REQ-035 Assert rst_n=0 during REPEAT at 400 -> target_temp 350 immediately, no further steps until re-press.
